prv32_muldiv: RTL
=================

Name: prv32_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, beside prv32_ALU, fed the same forwarded rs1/rs2 operands.
- Accepts one operation on a start pulse and runs a shared 32-step shift-add / restoring-divide datapath.
- Returns the 32-bit result with a one-cycle done pulse.
- Hazard logic holds the pipeline while busy is high.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- kill  input  1  pipeline flush; aborts any in-flight operation
- start  input  1  request; sampled only in IDLE
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  32  rs1 operand (multiplicand/dividend)
- b  input  32  rs2 operand (multiplier/divisor)
- busy  output  1  operation in flight; stall request
- done  output  1  one-cycle pulse; r valid this cycle
- r  output  32  result

Behaviour:
- Reset: rst (synchronous, active-high) forces state IDLE, busy=0, done=0, r=0, counter=0. It wins over kill and start in the same cycle. Reset mid-operation discards the operation; no done is produced.
- States:
  - IDLE: busy=0. Edge with start=1 and kill=0 latches op, sign flags, |a| and |b| (per op signedness), clears the 64-bit accumulator and count, and goes to RUN.
  - RUN: busy=1. One iteration per edge, count 0..31.
    - Multiply: if multiplier LSB is set, add multiplicand to the upper half; shift right 1.
    - Divide: shift remainder:quotient left 1; if remainder >= divisor, subtract and set the quotient LSB.
    - After the edge with count=31, go to FIX.
  - FIX: busy=1. Next edge applies sign correction, selects the result, writes r, pulses done=1 and returns to IDLE with busy=0.
- Latency: start sampled at edge E0; done=1 and r valid in the cycle after edge E33. busy is high for the 33 cycles following E0. Back-to-back: a new start may be sampled in the same cycle done=1, because state is IDLE then.
- start while busy: ignored; no queueing.
- kill: at any edge returns to IDLE, busy=0, done=0, r unchanged. kill together with start in IDLE: start is ignored.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU and DIVU/REMU: both unsigned.
  - DIV/REM: both signed.
- Product sign = sa XOR sb; 64-bit two's-complement negate when set.
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
- Quotient sign = sa XOR sb. Remainder takes the sign of the dividend.
- Divide by zero, required results (override in FIX):
  - DIV/DIVU: 0xFFFFFFFF.
  - REM/REMU: a unchanged.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, REM result 0.
- Special cases still take the full 33-cycle latency, so latency is deterministic.
- r holds its value between done pulses; done never asserts twice for one start.
- Width rule: magnitude of 0x80000000 is held as unsigned 2^31 in 32 bits, with no loss.

Decomposition:
- Add to defines.v:
  - `MD_MUL .. `MD_REMU funct3 codes.
  - 2-bit state encodings `MD_IDLE, `MD_RUN, `MD_FIX.
  - `MD_STEPS = 32.
- Single module, no sub-module. Mul and div share the 64-bit accumulator and 33-bit adder/subtractor, so splitting gains nothing.
- Integration (outside this block): the decoder raises start for OP with funct7=0000001. The EX-stage result mux selects r on done. Hazard unit stalls on busy.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> done exactly 33 cycles after start, r=0xFFFFFFEB; MULHU same operands -> r=0x00000006; MULH -> r=0xFFFFFFFF.
- MULHSU a=0xFFFFFFFF (-1), b=0xFFFFFFFF -> r=0xFFFFFFFF; MULH a=b=0x80000000 -> r=0x40000000.
- DIV a=-7, b=2 -> r=0xFFFFFFFD; REM a=-7, b=2 -> r=0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero a=0x12345678, b=0: DIV and DIVU -> 0xFFFFFFFF; REM and REMU -> 0x12345678. Overflow DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- kill asserted 10 cycles into a DIV -> busy=0 next cycle, no done, r keeps its previous value. A start pulse during busy -> ignored, exactly one done. A new start in the done cycle -> accepted, second done 33 cycles later.
- rst asserted mid-MUL together with start -> next cycle busy=0, done=0, r=0; a fresh op afterwards completes with the correct value.

Source files
------------

// File: rtl/prv32_muldiv_pkg.sv
// prv32_muldiv_pkg: funct3 codes, step count and state encoding for the M-extension unit.
package prv32_muldiv_pkg;
   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;
   localparam int MD_STEPS = 32;
   typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} md_state_e;
endpackage

// File: rtl/prv32_muldiv.sv
// prv32_muldiv: iterative RV32M multiply/divide; shared 64-bit accumulator and 33-bit adder,
// fixed 33-cycle latency from start to done.
module prv32_muldiv
   import prv32_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            kill,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] r
);
   md_state_e state, state_n;
   logic [2:0]  op_q;
   logic        sa, sb, divz;
   logic [31:0] m;
   logic [63:0] acc, acc_n, pn, p;
   logic [4:0]  cnt;
   logic        sgn_a, sgn_b, is_div;
   logic [31:0] abs_a, abs_b, q, rm, res;
   logic [32:0] x, y;
   logic [33:0] sum;
   always_comb begin
      sgn_a = op != MD_MULHU && op != MD_DIVU && op != MD_REMU;
      sgn_b = sgn_a && op != MD_MULHSU;
      abs_a = (sgn_a && a[31]) ? -a : a;
      abs_b = (sgn_b && b[31]) ? -b : b;
   end
   // mul: acc = {partial, multiplier}; div: acc = {remainder, quotient}. m is multiplicand or divisor.
   always_comb begin
      is_div = op_q[2];
      x      = is_div ? acc[63:31] : {1'b0, acc[63:32]};
      y      = (is_div || acc[0]) ? {1'b0, m} : 33'd0;
      sum    = {1'b0, x} + {1'b0, is_div ? ~y : y} + {33'd0, is_div};
      acc_n  = !is_div ? {sum[32:0], acc[31:1]} :
               sum[33] ? {sum[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0};
   end
   // The 64-bit negate doubles as the quotient negate; a zero divisor leaves |a| as remainder,
   // so REM/REMU return a without an explicit override.
   always_comb begin
      pn  = -acc;
      p   = (sa ^ sb) ? pn : acc;
      q   = divz ? 32'hFFFF_FFFF : (sa ^ sb) ? pn[31:0] : acc[31:0];
      rm  = sa ? -acc[63:32] : acc[63:32];
      res = op_q == MD_MUL ? p[31:0] : !op_q[2] ? p[63:32] : !op_q[1] ? q : rm;
   end
   always_comb begin
      state_n = kill ? MD_IDLE :
                state == MD_IDLE ? (start ? MD_RUN : MD_IDLE) :
                state == MD_RUN ? (cnt == 5'(MD_STEPS - 1) ? MD_FIX : MD_RUN) : MD_IDLE;
   end
   always_ff @(posedge clk) state <= rst ? MD_IDLE : state_n;
   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         cnt  <= '0;
         r    <= '0;
         done <= 1'b0;
         op_q <= '0;
         sa   <= 1'b0;
         sb   <= 1'b0;
         m    <= '0;
         divz <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!kill && state == MD_IDLE && start) begin
            op_q <= op;
            sa   <= sgn_a && a[31];
            sb   <= sgn_b && b[31];
            divz <= b == 32'd0;
            m    <= op[2] ? abs_b : abs_a;
            acc  <= {32'd0, op[2] ? abs_a : abs_b};
            cnt  <= '0;
         end else if (!kill && state == MD_RUN) begin
            acc <= acc_n;
            cnt <= cnt + 5'd1;
         end else if (!kill && state == MD_FIX) begin
            r    <= res;
            done <= 1'b1;
         end
      end
   end
   assign busy = state != MD_IDLE;
endmodule
